port_rx_packer: RTL and testbench

- Port-side source for the ring tap's prx interface: receives a byte-wide, non-stallable MAC receive stream and packs it into 64-bit port-format words.
- Each word is tagged with start-of-packet/end-of-packet, error and valid-byte-count fields.
- Absorbs srdy/drdy backpressure in a FIFO; on overflow, the packet is aborted cleanly and counted.
- One instance per port, driving prx_srdy/prx_data and consuming prx_drdy.

---
 rtl/port_rx_packer_if.sv | 12 +
 rtl/port_rx_packer.sv | 178 +++++++++++++++++
 tb/tb_port_rx_packer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/port_rx_packer_if.sv
// Port-format word stream from the receive packer toward the ring tap.
// The master presents words first-word-fall-through; the slave returns prx_drdy.
interface port_rx_packer_if #(
  parameter int pdp_sz = 70
);
  logic              prx_srdy;
  logic              prx_drdy;
  logic [pdp_sz-1:0] prx_data;

  modport master (output prx_srdy, output prx_data, input prx_drdy);
  modport slave  (input prx_srdy, input prx_data, output prx_drdy);
endinterface

// File: rtl/port_rx_packer.sv
// Packs a non-stallable byte-wide MAC receive stream into 70-bit port words.
// A small FWFT FIFO absorbs backpressure; overflowing packets are aborted and counted.
module port_rx_packer #(
  parameter int depth  = 8,
  parameter int asz    = 3,
  parameter int pdp_sz = 70
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_dv,
  input  logic                 rx_er,
  input  logic [7:0]           rxd,
  port_rx_packer_if.master     prx,
  output logic [15:0]          drop_cnt
);

  typedef enum logic [2:0] {
    SYNC  = 3'd0,
    IDLE  = 3'd1,
    RECV  = 3'd2,
    DROP  = 3'd3,
    ABORT = 3'd4
  } state_t;

  localparam logic [pdp_sz-1:0] ABORT_WORD = {2'b10, 1'b1, 3'b000, 64'd0};

  state_t r_state, w_next;

  logic [63:0]       r_word;
  logic [2:0]        r_idx;
  logic              r_err;
  logic              r_first;
  logic              r_full;
  logic              r_pushed_any;
  logic              r_seen_dv;
  logic [15:0]       r_drop_cnt;

  logic [pdp_sz-1:0] r_mem [depth];
  logic [asz:0]      r_wr_ptr;
  logic [asz:0]      r_rd_ptr;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_space;
  logic              w_push;
  logic [pdp_sz-1:0] w_push_word;
  logic              w_drop_inc;
  logic              w_start;
  logic              w_wr;

  // Extra pointer bit separates full from empty when the low bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[asz] != r_rd_ptr[asz]) &&
                   (r_wr_ptr[asz-1:0] == r_rd_ptr[asz-1:0]);
  assign w_pop   = !w_empty && prx.prx_drdy;
  assign w_space = !w_full || w_pop;

  assign prx.prx_srdy = !w_empty;
  assign prx.prx_data = w_empty ? '0 : r_mem[r_rd_ptr[asz-1:0]];
  assign drop_cnt     = r_drop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= SYNC;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_push      = 1'b0;
    w_push_word = '0;
    w_drop_inc  = 1'b0;
    w_start     = 1'b0;
    w_wr        = 1'b0;
    case (r_state)
      SYNC: begin
        if (!rx_dv) w_next = IDLE;
      end
      IDLE: begin
        if (rx_dv) begin
          w_start = 1'b1;
          w_next  = RECV;
        end
      end
      RECV: begin
        if (rx_dv) begin
          w_wr = 1'b1;
          // A full word is held back until the next byte proves it is not the last.
          if (r_full) begin
            w_push_word = {r_first ? 2'b01 : 2'b00, 1'b0, 3'b000, r_word};
            w_push      = w_space;
            if (!w_space) begin
              w_drop_inc = 1'b1;
              w_next     = DROP;
            end
          end
        end else begin
          w_push_word = {r_first ? 2'b11 : 2'b10, r_err, r_idx, r_word};
          w_push      = w_space;
          if (w_space) begin
            w_next = IDLE;
          end else begin
            w_drop_inc = 1'b1;
            w_next     = r_pushed_any ? ABORT : IDLE;
          end
        end
      end
      DROP: begin
        if (!rx_dv) w_next = r_pushed_any ? ABORT : IDLE;
      end
      ABORT: begin
        w_push_word = ABORT_WORD;
        if (w_space) begin
          w_push = 1'b1;
          // A packet that began while the abort was pending is lost as a whole.
          if (rx_dv || r_seen_dv) begin
            w_drop_inc = 1'b1;
            w_next     = rx_dv ? DROP : IDLE;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word       <= '0;
      r_idx        <= '0;
      r_err        <= 1'b0;
      r_first      <= 1'b0;
      r_full       <= 1'b0;
      r_pushed_any <= 1'b0;
      r_seen_dv    <= 1'b0;
    end else begin
      r_seen_dv <= (r_state == ABORT) && !w_push && (r_seen_dv || rx_dv);
      if (w_start) begin
        r_word       <= {56'd0, rxd};
        r_idx        <= 3'd1;
        r_err        <= rx_er;
        r_first      <= 1'b1;
        r_full       <= 1'b0;
        r_pushed_any <= 1'b0;
      end else if (w_wr) begin
        if (r_idx == 3'd0) r_word <= {56'd0, rxd};
        else               r_word[{r_idx, 3'b000} +: 8] <= rxd;
        r_idx  <= r_idx + 3'd1;
        r_err  <= r_err | rx_er;
        r_full <= (r_idx == 3'd7);
        if (w_push) begin
          r_first      <= 1'b0;
          r_pushed_any <= 1'b1;
        end
      end else if ((r_state == ABORT) && w_push) begin
        r_pushed_any <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[asz-1:0]] <= w_push_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_port_rx_packer.sv
// Scoreboard bench for port_rx_packer: packets are modelled as whole byte lists,
// expected words queued at issue time, and a negedge monitor pops on each transfer.
module tb_port_rx_packer;
  localparam int DEPTH = 4;
  localparam int ASZ   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rxDv = 1'b0;
  logic        rxEr = 1'b0;
  logic [7:0]  rxd = 8'd0;
  logic [15:0] dropCnt;

  port_rx_packer_if #(.pdp_sz(70)) prxIf ();

  port_rx_packer #(.depth(DEPTH), .asz(ASZ), .pdp_sz(70)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_dv    (rxDv),
    .rx_er    (rxEr),
    .rxd      (rxd),
    .prx      (prxIf),
    .drop_cnt (dropCnt)
  );

  always #5 clk = ~clk;

  logic [69:0] expQ [$];
  logic [7:0]  pkt [$];
  int          pktErr = -1;
  int          nChecks = 0;
  int          nFails = 0;
  int          drdyMode = 0;
  int          lowRun = 0;
  logic        prevStall = 1'b0;
  logic [69:0] prevData = '0;

  task automatic checkOutput(input string name, input logic [69:0] act, input logic [69:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Words of a packet follow from its byte list alone: 8 bytes per word, last word tagged.
  task automatic modelPacket();
    int n;
    int nw;
    logic anyErr;
    logic [63:0] data;
    logic last;
    n = pkt.size();
    nw = (n + 7) / 8;
    anyErr = (pktErr >= 0);
    for (int k = 0; k < nw; k++) begin
      data = '0;
      for (int j = 0; j < 8; j++)
        if (k * 8 + j < n) data[j*8 +: 8] = pkt[k*8 + j];
      last = (k == nw - 1);
      expQ.push_back({last, (k == 0), last ? anyErr : 1'b0, last ? 3'(n % 8) : 3'd0, data});
    end
  endtask

  task automatic fillRandom(input int len);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
  endtask

  task automatic fillCount(input int len);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(8'(i));
  endtask

  task automatic drivePacket(input int gap);
    for (int i = 0; i < pkt.size(); i++) begin
      rxDv = 1'b1;
      rxd  = pkt[i];
      rxEr = (i == pktErr);
      @(posedge clk); #1;
    end
    rxDv = 1'b0;
    rxEr = 1'b0;
    rxd  = 8'd0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic applyStimulus(input int errIdx, input int gap);
    pktErr = errIdx;
    modelPacket();
    drivePacket(gap);
    pktErr = -1;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 400; i++) begin
      if (expQ.size() == 0 && !prxIf.prx_srdy) break;
      @(posedge clk); #1;
    end
    checkOutput("drain_left", 70'(expQ.size()), 70'd0);
    checkOutput("drain_srdy", 70'(prxIf.prx_srdy), 70'd0);
  endtask

  // Random drdy never stays low more than two cycles, so the FIFO cannot overflow there.
  initial begin
    prxIf.prx_drdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (drdyMode)
        0: prxIf.prx_drdy = 1'b1;
        1: begin
          prxIf.prx_drdy = ($urandom_range(0, 1) == 1) || (lowRun >= 2);
          lowRun = prxIf.prx_drdy ? 0 : lowRun + 1;
        end
        default: prxIf.prx_drdy = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_srdy", 70'(prxIf.prx_srdy), 70'd1);
        checkOutput("stall_data", prxIf.prx_data, prevData);
      end
      if (prxIf.prx_srdy && prxIf.prx_drdy) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected_word: got %h, required no word", prxIf.prx_data);
        end else begin
          checkOutput("word", prxIf.prx_data, expQ.pop_front());
        end
      end
      prevStall = prxIf.prx_srdy && !prxIf.prx_drdy;
      prevData  = prxIf.prx_data;
    end
  end

  initial begin
    int len;
    int errIdx;
    logic [63:0] data;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_srdy", 70'(prxIf.prx_srdy), 70'd0);
    checkOutput("reset_data", prxIf.prx_data, 70'd0);
    checkOutput("reset_drop", 70'(dropCnt), 70'd0);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end

    pkt.delete();
    pkt.push_back(8'hA5);
    applyStimulus(-1, 2);
    fillCount(16);
    applyStimulus(-1, 2);
    fillRandom(13);
    applyStimulus(5, 2);
    waitDrain();

    drdyMode = 1;
    for (int p = 0; p < 8; p++) begin
      fillRandom(9);
      applyStimulus(-1, 1);
    end
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 40);
      errIdx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      fillRandom(len);
      applyStimulus(errIdx, $urandom_range(2, 4));
    end
    waitDrain();
    checkOutput("drop_after_random", 70'(dropCnt), 70'd0);

    drdyMode = 2;
    repeat (2) begin
      @(posedge clk); #1;
    end
    fillCount(64);
    for (int k = 0; k < DEPTH; k++) begin
      data = '0;
      for (int j = 0; j < 8; j++) data[j*8 +: 8] = pkt[k*8 + j];
      expQ.push_back({1'b0, (k == 0), 1'b0, 3'd0, data});
    end
    expQ.push_back({2'b10, 1'b1, 3'd0, 64'd0});
    drivePacket(3);
    checkOutput("overflow_drop", 70'(dropCnt), 70'd1);
    checkOutput("overflow_srdy", 70'(prxIf.prx_srdy), 70'd1);
    drdyMode = 0;
    waitDrain();
    fillRandom(8);
    applyStimulus(-1, 2);
    waitDrain();
    checkOutput("post_overflow_drop", 70'(dropCnt), 70'd1);

    drdyMode = 2;
    fillRandom(20);
    for (int i = 0; i < 20; i++) begin
      rxDv = 1'b1;
      rxd  = pkt[i];
      @(posedge clk); #1;
    end
    reset = 1'b0;
    expQ.delete();
    repeat (2) begin
      rxd = 8'($urandom);
      @(posedge clk); #1;
    end
    checkOutput("midreset_srdy", 70'(prxIf.prx_srdy), 70'd0);
    checkOutput("midreset_drop", 70'(dropCnt), 70'd0);
    reset = 1'b1;
    drdyMode = 0;
    repeat (6) begin
      rxd = 8'($urandom);
      @(posedge clk); #1;
    end
    rxDv = 1'b0;
    rxd  = 8'd0;
    @(posedge clk); #1;
    fillRandom(10);
    applyStimulus(-1, 2);
    waitDrain();
    checkOutput("final_drop", 70'(dropCnt), 70'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
